// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, fetch FSM state encoding and the FD register layout.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } fd_t;

  function automatic fd_t fd_bubble();
    fd_t b;
    b.instr    = NOP_INSTR;
    b.pc       = 32'h0;
    b.pc_plus4 = 32'h0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch with FD register; one instr/cycle on zero-wait memory, word visible in FD one edge after ack.
// StallD parks an acked word in a hold buffer with req low; a redirect with a request in flight drains the stale ack first.
module fetch_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pcf, pcf_nxt;
  logic [31:0]  redir_pc, redir_nxt;
  logic [31:0]  hold_buf, hold_nxt;
  fd_t          fd_q, fd_nxt;
  logic [31:0]  pcf_plus4;
  logic         deliver;
  logic [31:0]  deliver_instr;

  assign pcf_plus4 = pcf + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pcf      <= RESET_PC;
      redir_pc <= 32'h0;
      hold_buf <= 32'h0;
      fd_q     <= fd_bubble();
    end else begin
      state    <= state_nxt;
      pcf      <= pcf_nxt;
      redir_pc <= redir_nxt;
      hold_buf <= hold_nxt;
      fd_q     <= fd_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pcf_nxt       = pcf;
    redir_nxt     = redir_pc;
    hold_nxt      = hold_buf;
    deliver       = 1'b0;
    deliver_instr = hold_buf;
    case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (PCSrcE) begin
            pcf_nxt = PCTargetE;
          end else if (StallD) begin
            hold_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pcf_nxt       = pcf_plus4;
          end
        end else if (PCSrcE) begin
          redir_nxt = PCTargetE;
          state_nxt = S_KILL;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_nxt   = PCTargetE;
          state_nxt = S_REQ;
        end else if (!StallD) begin
          deliver   = 1'b1;
          pcf_nxt   = pcf_plus4;
          state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        // The address stays on the old PC until the in-flight ack retires it.
        if (PCSrcE) redir_nxt = PCTargetE;
        if (imem_ack) begin
          pcf_nxt   = PCSrcE ? PCTargetE : redir_pc;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    fd_nxt = fd_bubble();
    if (FlushD) begin
      fd_nxt = fd_bubble();
    end else if (StallD) begin
      fd_nxt = fd_q;
    end else if (deliver) begin
      fd_nxt.instr    = deliver_instr;
      fd_nxt.pc       = pcf;
      fd_nxt.pc_plus4 = pcf_plus4;
      fd_nxt.valid    = 1'b1;
    end
  end

  assign imem_req  = rst_n && ((state == S_REQ) || (state == S_KILL));
  assign imem_addr = pcf;
  assign InstrD    = fd_q.instr;
  assign PCD       = fd_q.pc;
  assign PCPlus4D  = fd_q.pc_plus4;
  assign ValidD    = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a variable-latency memory drives the DUT and a
// transaction-level model of the fetch rules predicts the request and FD contents every cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: fetch PC, an optional word waiting for decode, an optional stale
  // request being drained with its pending redirect target, and the FD contents.
  logic [31:0] m_pc, m_buf, m_redir;
  bit          m_have, m_drain;
  logic [31:0] m_instr, m_pcd, m_pc4;
  bit          m_valid;
  int          lat_left;
  bit          lat_armed;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) + 32'h1234_5671;
  endfunction

  task automatic model_bubble();
    m_instr = 32'h0000_0013; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_buf = 32'h0; m_redir = 32'h0;
    m_have = 1'b0; m_drain = 1'b0; lat_armed = 1'b0; lat_left = 0;
    model_bubble();
  endtask

  task automatic drive_idle();
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = rst_n && !m_have;
    check("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("InstrD", InstrD, m_instr);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pc4);
    check("ValidD", {31'h0, ValidD}, {31'h0, m_valid});
  endtask

  task automatic step(input int maxlat, input int stall_pct, input int flush_pct,
                      input int br_pct, input bit hi_tgt, input bit force_br);
    bit          stall, flush, br, ack, deliver;
    logic [31:0] tgt, dw, dpc;
    @(negedge clk);
    check_outputs();
    stall = ($urandom_range(0, 99) < stall_pct);
    flush = ($urandom_range(0, 99) < flush_pct);
    br    = force_br || ($urandom_range(0, 99) < br_pct);
    tgt   = hi_tgt ? (32'hFFFF_FFF0 + 32'd4 * $urandom_range(0, 3))
                   : ($urandom_range(0, 1023) << 2);
    ack   = 1'b0;
    if (!m_have) begin
      if (!lat_armed) begin
        lat_left  = $urandom_range(0, maxlat);
        lat_armed = 1'b1;
      end
      if (lat_left == 0) begin
        ack = 1'b1; lat_armed = 1'b0;
      end else lat_left--;
    end
    StallD = stall; FlushD = flush; PCSrcE = br; PCTargetE = tgt;
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(m_pc) : $urandom;

    deliver = 1'b0; dw = 32'h0; dpc = 32'h0;
    if (m_drain) begin
      if (br) m_redir = tgt;
      if (ack) begin
        m_pc = br ? tgt : m_redir; m_drain = 1'b0;
      end
    end else if (m_have) begin
      if (br) begin
        m_pc = tgt; m_have = 1'b0;
      end else if (!stall) begin
        deliver = 1'b1; dw = m_buf; dpc = m_pc; m_pc = m_pc + 32'd4; m_have = 1'b0;
      end
    end else if (br) begin
      if (ack) m_pc = tgt;
      else begin
        m_drain = 1'b1; m_redir = tgt;
      end
    end else if (ack) begin
      if (stall) begin
        m_have = 1'b1; m_buf = imem_rdata;
      end else begin
        deliver = 1'b1; dw = imem_rdata; dpc = m_pc; m_pc = m_pc + 32'd4;
      end
    end

    if (flush) model_bubble();
    else if (stall) begin
      // FD keeps its contents
    end else if (deliver) begin
      m_instr = dw; m_pcd = dpc; m_pc4 = dpc + 32'd4; m_valid = 1'b1;
    end else model_bubble();
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    drive_idle();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, ValidD}, 32'h0);
    check("rst_instr", InstrD, 32'h0000_0013);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
      imem_ack = $urandom_range(0, 1);
    end
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    drive_idle();
  endtask

  // Phase table: cycles, max ack latency, stall%, flush%, branch%, high targets
  localparam int NPH = 7;
  int ph_n   [NPH] = '{8, 60, 80, 80, 60, 30, 300};
  int ph_lat [NPH] = '{0,  3,  2,  3,  2,  0,   3};
  int ph_st  [NPH] = '{0,  0, 40,  0, 40,  0,  25};
  int ph_fl  [NPH] = '{0,  0,  0,  0, 30,  0,  10};
  int ph_br  [NPH] = '{0,  0,  0, 15,  0,  5,  10};
  bit ph_hi  [NPH] = '{0,  0,  0,  0,  0,  1,   0};

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    do_reset();

    for (int p = 0; p < NPH; p++)
      for (int c = 0; c < ph_n[p]; c++)
        step(ph_lat[p], ph_st[p], ph_fl[p], ph_br[p], ph_hi[p], ph_hi[p] && (c == 0));

    // Reach the drain state, then reset in the middle of it.
    begin
      int guard = 0;
      while (!m_drain && guard < 300) begin
        step(4, 0, 0, 30, 1'b0, 1'b0);
        guard++;
      end
      check("kill_reached", {31'h0, m_drain}, 32'h1);
    end
    do_reset();

    for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 200; c++) step(3, 25, 10, 10, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
